line_follow_nav_ctrl: RTL and testbench

//  Parametrised line-follow and navigation controller for the two-motor bot. Compares three
//  ADC line-sensor readings against thresholds and drives the H-bridge inputs with a

---
 rtl/line_follow_nav_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_line_follow_nav_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_follow_nav_ctrl.sv
// line_follow_nav_ctrl
//   Line-follow and navigation controller for the two-motor bot. Thresholds three
//   ADC line-sensor samples, steers the H-bridge with a runtime-duty PWM, counts
//   nodes (all three sensors on the line) behind a blanking window, and runs a
//   per-node action (straight / left / right / stop) from a path-plan vector.
// Ports
//   clk, rst          system clock; asynchronous active-low reset
//   start             level, sampled only in IDLE to begin the run
//   duty              PWM on-count (0 = always off)
//   left/center/right_sensor   ADC samples
//   path_plan         action for node k at [2k+1:2k]: 00 straight, 01 left, 10 right, 11 stop
//   M1_A_1A_right/M1_A_1B      right motor forward / backward
//   M2_A_1A_left/M2_A_1B       left motor forward / backward
//   led               toggles on every counted node
//   node_count        saturating count of nodes
//   busy / done       run in progress / run finished
module line_follow_nav_ctrl #(
  parameter int ADC_W     = 12,
  parameter int LINE_TH   = 500,
  parameter int LOST_TH   = 200,
  parameter int PWM_W     = 4,
  parameter int NODE_W    = 4,
  parameter int MAX_NODES = 16,
  parameter int STOP_CYC  = 3_125_000,
  parameter int TURN_CYC  = 6_250_000,
  parameter int BLANK_CYC = 6_250_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PWM_W-1:0]       duty,
  input  logic [ADC_W-1:0]       left_sensor,
  input  logic [ADC_W-1:0]       center_sensor,
  input  logic [ADC_W-1:0]       right_sensor,
  input  logic [2*MAX_NODES-1:0] path_plan,
  output logic                   M1_A_1A_right,
  output logic                   M1_A_1B,
  output logic                   M2_A_1A_left,
  output logic                   M2_A_1B,
  output logic                   led,
  output logic [NODE_W-1:0]      node_count,
  output logic                   busy,
  output logic                   done
);

  localparam int SW = (STOP_CYC > 1) ? $clog2(STOP_CYC) : 1;
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLLOW,
    S_NODE_STOP,
    S_TURN,
    S_DONE
  } state_t;

  state_t            state;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              pwm;
  logic [BW-1:0]     blank_cnt;
  logic [SW-1:0]     stop_cnt;
  logic [TW-1:0]     turn_cnt;
  logic [NODE_W-1:0] k_lat;
  logic              turn_right;

  logic              on_l, on_c, on_r, lost;
  logic              node_evt;
  logic              last_node;
  logic [1:0]        act;
  // Motor vectors ordered {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B}
  logic [3:0]        steer_mot, pivl_mot, pivr_mot;

  always_comb begin
    pwm      = (pwm_cnt < duty);
    on_l     = (left_sensor   > ADC_W'(LINE_TH));
    on_c     = (center_sensor > ADC_W'(LINE_TH));
    on_r     = (right_sensor  > ADC_W'(LINE_TH));
    lost     = (left_sensor   < ADC_W'(LOST_TH)) &&
               (center_sensor < ADC_W'(LOST_TH)) &&
               (right_sensor  < ADC_W'(LOST_TH));
    pivl_mot = {pwm, 1'b0, 1'b0, pwm};
    pivr_mot = {1'b0, pwm, pwm, 1'b0};
    if (lost)                steer_mot = {1'b0, pwm, 1'b0, pwm};
    else if (on_l && !on_r)  steer_mot = pivl_mot;
    else if (!on_l && on_r)  steer_mot = pivr_mot;
    else                     steer_mot = {pwm, 1'b0, pwm, 1'b0};
    node_evt = (state == S_FOLLOW) && on_l && on_c && on_r && (blank_cnt == '0);
  end

  // Plan lookup by loop keeps the index inside the vector for any k.
  always_comb begin
    act = 2'b00;
    for (int unsigned i = 0; i < MAX_NODES; i++) begin
      if (32'(k_lat) == i) act = path_plan[2*i +: 2];
    end
    last_node = ((32'(k_lat) + 32'd1) >= 32'(MAX_NODES));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt <= '0;
    else      pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  // Blank window runs in every state once loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 blank_cnt <= '0;
    else if (node_evt)        blank_cnt <= BW'(BLANK_CYC);
    else if (blank_cnt != '0) blank_cnt <= blank_cnt - BW'(1);
  end

  // Outputs are loaded on the edge that enters a state, so each state's motor
  // pattern is visible for exactly the cycles the state lasts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      M1_A_1A_right <= 1'b0;
      M1_A_1B       <= 1'b0;
      M2_A_1A_left  <= 1'b0;
      M2_A_1B       <= 1'b0;
      led           <= 1'b0;
      node_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      stop_cnt      <= '0;
      turn_cnt      <= '0;
      k_lat         <= '0;
      turn_right    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= '0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state <= S_FOLLOW;
            busy  <= 1'b1;
            {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= steer_mot;
          end
        end

        S_FOLLOW: begin
          if (node_evt) begin
            state    <= S_NODE_STOP;
            stop_cnt <= '0;
            k_lat    <= node_count;
            led      <= ~led;
            if (node_count != '1) node_count <= node_count + NODE_W'(1);
            {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= '0;
          end else begin
            {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= steer_mot;
          end
        end

        S_NODE_STOP: begin
          {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= '0;
          if (stop_cnt == SW'(STOP_CYC - 1)) begin
            stop_cnt <= '0;
            if (last_node || (act == 2'b11)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (act == 2'b00) begin
              state <= S_FOLLOW;
              {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= steer_mot;
            end else begin
              state      <= S_TURN;
              turn_cnt   <= '0;
              turn_right <= act[1];
              {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <=
                act[1] ? pivr_mot : pivl_mot;
            end
          end else begin
            stop_cnt <= stop_cnt + SW'(1);
          end
        end

        S_TURN: begin
          if (turn_cnt == TW'(TURN_CYC - 1)) begin
            turn_cnt <= '0;
            state    <= S_FOLLOW;
            {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= steer_mot;
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
            {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <=
              turn_right ? pivr_mot : pivl_mot;
          end
        end

        S_DONE: begin
          {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= '0;
          busy <= 1'b0;
          done <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          {M1_A_1A_right, M1_A_1B, M2_A_1A_left, M2_A_1B} <= '0;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_follow_nav_ctrl.sv
// Self-checking bench for line_follow_nav_ctrl with short timing parameters.
// Expected observation vectors are queued before each clock edge and popped
// and compared after it.
module tb_line_follow_nav_ctrl;

  localparam int M_Z = 0, M_F = 1, M_R = 2, M_PL = 3, M_PR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  duty = 4'd8;
  logic [11:0] ls = 12'd100, cs = 12'd900, rs = 12'd100;
  logic [31:0] plan = '0;
  logic [5:0]  plan3 = '0;

  logic m1a, m1b, m2a, m2b, led, busy, done;
  logic [3:0] node_count;
  logic n1a, n1b, n2a, n2b, led3, busy3, done3;
  logic [3:0] node_count3;

  int tests = 0;
  int fails = 0;
  logic [3:0] pcnt;
  logic [10:0] sb[$];
  logic [10:0] e;

  wire [10:0] obs  = {m1a, m1b, m2a, m2b, node_count, led, busy, done};
  wire [10:0] obs3 = {n1a, n1b, n2a, n2b, node_count3, led3, busy3, done3};

  always #5 clk = ~clk;

  line_follow_nav_ctrl #(.STOP_CYC(4), .TURN_CYC(6), .BLANK_CYC(10), .PWM_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .duty(duty),
    .left_sensor(ls), .center_sensor(cs), .right_sensor(rs), .path_plan(plan),
    .M1_A_1A_right(m1a), .M1_A_1B(m1b), .M2_A_1A_left(m2a), .M2_A_1B(m2b),
    .led(led), .node_count(node_count), .busy(busy), .done(done));

  line_follow_nav_ctrl #(.STOP_CYC(4), .TURN_CYC(6), .BLANK_CYC(10), .PWM_W(4),
                         .MAX_NODES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .duty(duty),
    .left_sensor(ls), .center_sensor(cs), .right_sensor(rs), .path_plan(plan3),
    .M1_A_1A_right(n1a), .M1_A_1B(n1b), .M2_A_1A_left(n2a), .M2_A_1B(n2b),
    .led(led3), .node_count(node_count3), .busy(busy3), .done(done3));

  // Reference PWM phase: free-running from reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) pcnt <= '0;
    else      pcnt <= pcnt + 4'd1;
  end

  function automatic logic [3:0] mexp(int mode);
    logic p;
    p = (pcnt < duty);
    case (mode)
      M_F:     return {p, 1'b0, p, 1'b0};
      M_R:     return {1'b0, p, 1'b0, p};
      M_PL:    return {p, 1'b0, 1'b0, p};
      M_PR:    return {1'b0, p, p, 1'b0};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [10:0] ex(int mode, int cnt, logic l, logic b, logic d);
    return {mexp(mode), 4'(cnt), l, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0; duty = 4'd8; ls = 12'd100; cs = 12'd900; rs = 12'd100; plan = '0;
    rst = 1'b0;
    #3;
    tests++;
    if (obs !== 11'd0) begin
      fails++;
      $display("FAIL reset_state got %b expected %b", obs, 11'd0);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex(M_Z, 0, 1'b0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL idle_hold cyc %0d got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_follow_pwm();
    int highs;
    highs = 0;
    start = 1'b1;
    sb.push_back(ex(M_F, 0, 1'b0, 1'b1, 1'b0));
    tick();
    start = 1'b0;
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL start_follow got %b expected %b", obs, e);
    end
    for (int i = 0; i < 16; i++) begin
      sb.push_back(ex(M_F, 0, 1'b0, 1'b1, 1'b0));
      tick();
      if (m1a) highs++;
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL follow_fwd cyc %0d got %b expected %b", i, obs, e);
      end
    end
    tests++;
    if (highs != 8) begin
      fails++;
      $display("FAIL pwm_duty8 got %0d high expected 8", highs);
    end
  endtask

  task automatic test_steering();
    ls = 12'd900; cs = 12'd900; rs = 12'd100;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(ex(M_PL, 0, 1'b0, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL steer_left cyc %0d got %b expected %b", i, obs, e);
      end
    end
    ls = 12'd100; cs = 12'd900; rs = 12'd900;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(ex(M_PR, 0, 1'b0, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL steer_right cyc %0d got %b expected %b", i, obs, e);
      end
    end
    ls = 12'd50; cs = 12'd50; rs = 12'd50;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(ex(M_R, 0, 1'b0, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL steer_reverse cyc %0d got %b expected %b", i, obs, e);
      end
    end
    duty = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex(M_Z, 0, 1'b0, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL duty_zero cyc %0d got %b expected %b", i, obs, e);
      end
    end
    duty = 4'd8;
  endtask

  task automatic test_node_blank();
    int mode, cnt;
    logic l;
    ls = 12'd900; cs = 12'd900; rs = 12'd900;
    for (int i = 0; i < 20; i++) begin
      mode = (i < 4) ? M_Z : (i < 11) ? M_F : (i < 15) ? M_Z : M_F;
      cnt  = (i < 11) ? 1 : 2;
      l    = (i < 11);
      sb.push_back(ex(mode, cnt, l, 1'b1, 1'b0));
      tick();
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL node_blank cyc %0d got %b expected %b", i, obs, e);
      end
    end
    ls = 12'd100; cs = 12'd900; rs = 12'd100;
  endtask

  task automatic test_turn_and_stop();
    apply_reset();
    plan = '0;
    plan[1:0] = 2'b01;
    plan[3:2] = 2'b11;
    ls = 12'd100; cs = 12'd900; rs = 12'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ls = 12'd900; rs = 12'd900;
    for (int i = 0; i < 14; i++) begin
      sb.push_back(ex((i < 4) ? M_Z : (i < 10) ? M_PL : M_F, 1, 1'b1, 1'b1, 1'b0));
      tick();
      if (i == 0) begin ls = 12'd100; rs = 12'd100; end
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL node0_left cyc %0d got %b expected %b", i, obs, e);
      end
    end
    ls = 12'd900; rs = 12'd900;
    for (int i = 0; i < 9; i++) begin
      start = (i >= 5);
      if (i < 4) sb.push_back(ex(M_Z, 2, 1'b0, 1'b1, 1'b0));
      else       sb.push_back(ex(M_Z, 2, 1'b0, 1'b0, 1'b1));
      tick();
      if (i == 0) begin ls = 12'd100; rs = 12'd100; end
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL node1_done cyc %0d got %b expected %b", i, obs, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_turn();
    apply_reset();
    plan = '0;
    plan[1:0] = 2'b10;
    plan[3:2] = 2'b11;
    for (int pass = 0; pass < 2; pass++) begin
      ls = 12'd100; cs = 12'd900; rs = 12'd100;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      ls = 12'd900; rs = 12'd900;
      for (int i = 0; i < ((pass == 0) ? 7 : 12); i++) begin
        sb.push_back(ex((i < 4) ? M_Z : (i < 10) ? M_PR : M_F, 1, 1'b1, 1'b1, 1'b0));
        tick();
        if (i == 0) begin ls = 12'd100; rs = 12'd100; end
        e = sb.pop_front();
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL turn_right pass %0d cyc %0d got %b expected %b", pass, i, obs, e);
        end
      end
      if (pass == 0) begin
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (obs !== 11'd0) begin
          fails++;
          $display("FAIL async_reset got %b expected %b", obs, 11'd0);
        end
        tick();
        rst = 1'b1;
      end
    end
  endtask

  task automatic test_max_nodes();
    apply_reset();
    plan = '0;
    plan3 = '0;
    ls = 12'd100; cs = 12'd900; rs = 12'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int n = 0; n < 3; n++) begin
      ls = 12'd900; rs = 12'd900;
      tick();
      ls = 12'd100; rs = 12'd100;
      tick(); tick(); tick();
      if (n < 2) sb.push_back({mexp(M_F), 4'(n + 1), (n == 0), 1'b1, 1'b0});
      else       sb.push_back({4'b0000, 4'd3, 1'b1, 1'b0, 1'b1});
      tick();
      e = sb.pop_front();
      tests++;
      if (obs3 !== e) begin
        fails++;
        $display("FAIL max_nodes node %0d got %b expected %b", n, obs3, e);
      end
      repeat (12) tick();
    end
    tests++;
    if (obs3 !== {4'b0000, 4'd3, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL max_nodes_hold got %b expected %b", obs3, {4'b0000, 4'd3, 1'b1, 1'b0, 1'b1});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_follow_pwm();
    test_steering();
    test_node_blank();
    test_turn_and_stop();
    test_reset_mid_turn();
    test_max_nodes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
